// File: rtl/filtered_synchronizer.sv
// filtered_synchronizer
//   Brings WIDTH independent asynchronous channels into the clock domain
//   through a STAGES-deep flip-flop chain. Each synchronized channel then
//   passes through a stability filter: data_out follows the synchronized
//   value only after it has disagreed with data_out for FILTER consecutive
//   clock edges. Registered one-cycle pulses mark every 0->1 and 1->0
//   change of data_out.
//
// Parameters
//   WIDTH        number of independent channels
//   STAGES       synchronizer flops per channel (>= 1)
//   FILTER       consecutive disagreeing edges needed to update (>= 1)
//   RESET_VALUE  value of the synchronizer chains and data_out in reset
//
// Ports
//   clock         single clock for all logic
//   resetn        asynchronous, active-low reset
//   data_in       [WIDTH] asynchronous input channels
//   data_out      [WIDTH] synchronized, filtered channel values
//   rising_edge   [WIDTH] one-cycle pulse in the cycle data_out goes 0->1
//   falling_edge  [WIDTH] one-cycle pulse in the cycle data_out goes 1->0
module filtered_synchronizer #(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 2,
  parameter int               FILTER      = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rising_edge,
  output logic [WIDTH-1:0] falling_edge
);

  // Counter only has to reach FILTER-1; keep at least one bit so FILTER=1
  // still elaborates to a legal vector.
  localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER - 1);

  if (FILTER < 1) begin : g_bad_filter
    $error("filtered_synchronizer: FILTER must be >= 1");
  end
  if (STAGES < 1) begin : g_bad_stages
    $error("filtered_synchronizer: STAGES must be >= 1");
  end

  // ------------------------------------------------------------------
  // Synchronizer chain. chain[0] samples the asynchronous input; the last
  // stage is the synchronized value seen by the filter.
  // ------------------------------------------------------------------
  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] sync;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= RESET_VALUE;
      end
    end else begin
      chain[0] <= data_in;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign sync = chain[STAGES-1];

  // ------------------------------------------------------------------
  // Stability filter. A channel's counter runs while sync disagrees with
  // data_out and clears as soon as they agree again, so only an
  // uninterrupted run of FILTER disagreeing edges moves data_out.
  // ------------------------------------------------------------------
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] differ;
  logic [WIDTH-1:0] load;

  always_comb begin
    differ = sync ^ data_out;
    load   = '0;
    for (int b = 0; b < WIDTH; b++) begin
      load[b] = differ[b] && (cnt[b] == CNT_MAX);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int b = 0; b < WIDTH; b++) begin
        cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        if (!differ[b] || load[b]) begin
          cnt[b] <= '0;
        end else begin
          cnt[b] <= cnt[b] + CW'(1);
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Output and edge registers. A load always flips the channel, so the
  // direction of the change is simply the new sync value.
  // ------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_out     <= RESET_VALUE;
      rising_edge  <= '0;
      falling_edge <= '0;
    end else begin
      data_out     <= (data_out & ~load) | (sync & load);
      rising_edge  <= load & sync;
      falling_edge <= load & ~sync;
    end
  end

endmodule

// File: doc/filtered_synchronizer.md
FILTERED_SYNCHRONIZER -- requirements
Module: filtered_synchronizer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1: number of independent channels.
REQ-002 The block SHALL have parameter STAGES, default 2: flip-flop stages in each channel's synchronizer chain; legal range >=1.
REQ-003 The block SHALL have parameter FILTER, default 4: consecutive stable cycles required before the output follows; legal range >=1, and 0 SHALL cause an elaboration error.
REQ-004 The block SHALL have parameter RESET_VALUE, default '0, WIDTH bits: value of the synchronizer chains and data_out during reset.
REQ-005 The block SHALL have port clock  input  1  single clock for all logic.
REQ-006 The block SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port data_in  input  WIDTH  asynchronous input channels.
REQ-008 The block SHALL have port data_out  output  WIDTH  synchronized, filtered channel values.
REQ-009 The block SHALL have port rising_edge  output  WIDTH  one-cycle pulse per channel on a data_out 0->1 transition.
REQ-010 The block SHALL have port falling_edge  output  WIDTH  one-cycle pulse per channel on a data_out 1->0 transition.

Function
REQ-011 Each channel SHALL be processed independently; no channel's state SHALL affect another channel.
REQ-012 Each channel SHALL pass data_in through a STAGES-deep flip-flop chain; the chain output is "sync".
REQ-013 A value on data_in set up before clock edge E0 SHALL appear on sync after edge E0+STAGES-1.
REQ-014 Each channel SHALL hold a counter of width $clog2(FILTER) (minimum 1 bit).
REQ-015 On each edge where sync==data_out, the counter SHALL clear to 0.
REQ-016 On each edge where sync!=data_out and counter<FILTER-1, the counter SHALL increment.
REQ-017 On each edge where sync!=data_out and counter==FILTER-1, data_out SHALL load sync and the counter SHALL clear.
REQ-018 Total latency from E0 to data_out SHALL be STAGES+FILTER edges, so the new value is visible after edge E0+STAGES+FILTER-1.
REQ-019 With FILTER=1, data_out SHALL equal sync delayed by exactly one register, with no filtering.
REQ-020 A sync excursion lasting fewer than FILTER cycles SHALL leave data_out unchanged and produce no edge pulse.
REQ-021 rising_edge/falling_edge SHALL be registered and high for exactly the one cycle in which data_out first shows the new value.
REQ-022 Edge pulses SHALL NOT be generated when data_out is unchanged.
REQ-023 Simultaneous transitions on different channels SHALL produce their pulses in the same cycle.

Reset
REQ-024 While resetn=0, the synchronizer chains and data_out SHALL equal RESET_VALUE, regardless of data_in and clock.
REQ-025 While resetn=0, counters, rising_edge and falling_edge SHALL be 0, and outputs SHALL take these values immediately on resetn falling, without a clock edge.
REQ-026 Reset asserted mid-count SHALL discard all pending transitions.
REQ-027 After reset release, data_in differing from RESET_VALUE SHALL propagate with the full REQ-018 latency and produce the normal edge pulse.
REQ-028 No edge pulse SHALL be produced by reset assertion or release itself.

Verification
Common configuration for REQ-029..REQ-033: WIDTH=4, STAGES=2, FILTER=3, RESET_VALUE=4'b0000, transitions at 25% of the cycle before E0.
REQ-029 resetn=0, data_in=4'hF, clock running -> data_out=4'h0, rising_edge=0, falling_edge=0 throughout reset.
REQ-030 data_in 4'h0->4'h1 before E0 -> data_out=4'h1 after edge E0+4 and not earlier; rising_edge=4'h1 for exactly the cycle after E0+4; falling_edge stays 0.
REQ-031 data_in[1] pulsed high for 2 cycles, also repeated at 75% timing -> data_out and edge outputs stay 0; a 3-cycle pulse propagates with rising then falling pulses 3 cycles apart.
REQ-032 From data_out=4'h1, data_in->4'h4 before E0 -> after E0+4, data_out=4'h4 with falling_edge=4'h1 and rising_edge=4'h4 in the same single cycle.
REQ-033 data_in 4'h0->4'hF, resetn pulsed low after E0+2 -> outputs return to 4'h0 asynchronously; after release at edge R, data_out=4'hF after R+4 (counting R as E0) with one rising_edge=4'hF pulse.
REQ-034 Sweep STAGES 1..5 with FILTER=1, and FILTER 1..5 with STAGES=2, using 0->1 and 1->0 steps at 25% and 75% of the cycle -> latency exactly STAGES+FILTER edges in every case.
